// File: rtl/table_walk_param.sv
// Two-level page table walker: L1 descriptor read, L2 descriptor read, then a one-cycle done pulse.
// Optional descriptor fault detection is enabled by defining TABLE_WALK_FAULT_CHECK_EN.
module table_walk_param #(
    parameter int VA_W     = 14,
    parameter int PA_W     = 14,
    parameter int L1_IDX_W = 5,
    parameter int L2_IDX_W = 4,
    parameter int OFF_W    = 5
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic            in_req,
    input  logic [VA_W-1:0] in_mva,
    input  logic [PA_W-1:0] in_ttb,
    output logic            out_busy,
    output logic            out_done,
    output logic [PA_W-1:0] out_paddr,
    output logic            out_fault,
    output logic            out_mcu_ren,
    output logic [PA_W-1:0] out_mcu_addr,
    output logic [1:0]      out_mcu_size,
    input  logic [31:0]     in_mcu_data,
    input  logic            in_mcu_valid
);

    localparam int TTB_HI_W = PA_W - L1_IDX_W - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_L1_RD = 2'd1,
        S_L2_RD = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [VA_W-1:0]       mva_q, mva_d;
    logic [TTB_HI_W-1:0]   ttb_hi_q, ttb_hi_d;
    logic [PA_W-1:0]       l2_addr_q, l2_addr_d;
    logic [PA_W-1:0]       paddr_q, paddr_d;

    logic [L1_IDX_W-1:0]   l1_idx;
    logic [L2_IDX_W-1:0]   l2_idx;
    logic [OFF_W-1:0]      pg_off;
    logic                  desc_fault;

    assign l1_idx = mva_q[VA_W-1 -: L1_IDX_W];
    assign l2_idx = mva_q[VA_W-L1_IDX_W-1 -: L2_IDX_W];
    assign pg_off = mva_q[OFF_W-1:0];

`ifdef TABLE_WALK_FAULT_CHECK_EN
    logic fault_q, fault_d;

    // An invalid descriptor carries type bits 2'b00 at either level.
    assign desc_fault = (in_mcu_data[1:0] == 2'b00);

    always_comb begin
        fault_d = fault_q;
        if (state_q == S_IDLE && in_req) begin
            fault_d = 1'b0;
        end else if ((state_q == S_L1_RD || state_q == S_L2_RD) && in_mcu_valid && desc_fault) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign out_fault = fault_q;
`else
    assign desc_fault = 1'b0;
    assign out_fault  = 1'b0;
`endif

    // Descriptor high bits and TTB low bits are architecturally ignored.
    logic unused_bits;
    assign unused_bits = ^{in_mcu_data, in_ttb};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        mva_d        = mva_q;
        ttb_hi_d     = ttb_hi_q;
        l2_addr_d    = l2_addr_q;
        paddr_d      = paddr_q;
        out_mcu_ren  = 1'b0;
        out_mcu_addr = '0;
        out_mcu_size = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (in_req) begin
                    mva_d    = in_mva;
                    ttb_hi_d = in_ttb[PA_W-1:L1_IDX_W+2];
                    state_d  = S_L1_RD;
                end
            end
            S_L1_RD: begin
                out_mcu_ren  = 1'b1;
                out_mcu_size = 2'b10;
                out_mcu_addr = {ttb_hi_q, l1_idx, 2'b00};
                if (in_mcu_valid) begin
                    if (desc_fault) begin
                        paddr_d = '0;
                        state_d = S_DONE;
                    end else begin
                        l2_addr_d = {in_mcu_data[PA_W-1:L2_IDX_W+2], l2_idx, 2'b00};
                        state_d   = S_L2_RD;
                    end
                end
            end
            S_L2_RD: begin
                out_mcu_ren  = 1'b1;
                out_mcu_size = 2'b10;
                out_mcu_addr = l2_addr_q;
                if (in_mcu_valid) begin
                    if (desc_fault) begin
                        paddr_d = '0;
                    end else begin
                        paddr_d = {in_mcu_data[PA_W-1:OFF_W], pg_off};
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!in_rst_n) begin
            state_q   <= S_IDLE;
            mva_q     <= '0;
            ttb_hi_q  <= '0;
            l2_addr_q <= '0;
            paddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            mva_q     <= mva_d;
            ttb_hi_q  <= ttb_hi_d;
            l2_addr_q <= l2_addr_d;
            paddr_q   <= paddr_d;
        end
    end

    assign out_busy  = (state_q != S_IDLE);
    assign out_done  = (state_q == S_DONE);
    assign out_paddr = paddr_q;

endmodule

// File: tb/tb_table_walk_param.sv
// Directed bench for table_walk_param: behavioural MCU with programmable wait, hand-computed walks.
// Fault-check expectations follow TABLE_WALK_FAULT_CHECK_EN when it is defined for the build.
module tb_table_walk_param;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_req = 1'b0;
    logic [13:0] in_mva = '0;
    logic [13:0] in_ttb = '0;
    logic        out_busy;
    logic        out_done;
    logic [13:0] out_paddr;
    logic        out_fault;
    logic        out_mcu_ren;
    logic [13:0] out_mcu_addr;
    logic [1:0]  out_mcu_size;
    logic [31:0] in_mcu_data = '0;
    logic        in_mcu_valid = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // MCU model configuration: wait cycles and a two-entry address/data table.
    int          mcu_wait = 0;
    int          wait_cnt = 0;
    logic [13:0] mem_a0, mem_a1;
    logic [31:0] mem_d0, mem_d1;

    table_walk_param dut (
        .in_clk      (in_clk),
        .in_rst_n    (in_rst_n),
        .in_req      (in_req),
        .in_mva      (in_mva),
        .in_ttb      (in_ttb),
        .out_busy    (out_busy),
        .out_done    (out_done),
        .out_paddr   (out_paddr),
        .out_fault   (out_fault),
        .out_mcu_ren (out_mcu_ren),
        .out_mcu_addr(out_mcu_addr),
        .out_mcu_size(out_mcu_size),
        .in_mcu_data (in_mcu_data),
        .in_mcu_valid(in_mcu_valid)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_lookup(input logic [13:0] a);
        if (a == mem_a0) return mem_d0;
        if (a == mem_a1) return mem_d1;
        return 32'hDEAD_BEE1;
    endfunction

    // Responds one tick after each rising edge; valid after mcu_wait idle cycles of ren.
    always begin
        @(posedge in_clk);
        #1;
        if (!in_rst_n || !out_mcu_ren) begin
            in_mcu_valid = 1'b0;
            in_mcu_data  = '0;
            wait_cnt     = 0;
        end else if (wait_cnt >= mcu_wait) begin
            in_mcu_valid = 1'b1;
            in_mcu_data  = mem_lookup(out_mcu_addr);
            wait_cnt     = 0;
        end else begin
            in_mcu_valid = 1'b0;
            in_mcu_data  = '0;
            wait_cnt     = wait_cnt + 1;
        end
    end

    // Issues one request and follows it to out_done; all timing relative to the request cycle.
    task automatic do_walk(input string tag, input logic [13:0] mva, input logic [13:0] ttb,
                           input int exp_reads, input logic [13:0] exp_a0, input logic [13:0] exp_a1,
                           input int exp_lat, input logic [13:0] exp_paddr, input logic exp_fault);
        int          cyc = 0;
        int          nreads = 0;
        bit          read_start = 1'b1;
        bit          seen_done = 1'b0;
        logic [13:0] start_addr = '0;
        logic [13:0] rd [2];
        rd[0] = '0;
        rd[1] = '0;
        @(posedge in_clk);
        #2;
        in_req = 1'b1;
        in_mva = mva;
        in_ttb = ttb;
        @(negedge in_clk);
        check({tag, "_idle_before"}, {31'd0, out_busy}, 32'd0);
        while (!seen_done && cyc < 40) begin
            @(posedge in_clk);
            #2;
            in_req = 1'b0;
            cyc++;
            @(negedge in_clk);
            if (out_mcu_ren) begin
                if (read_start) begin
                    start_addr = out_mcu_addr;
                    read_start = 1'b0;
                end
                if (in_mcu_valid) begin
                    check({tag, "_addr_stable"}, {18'd0, out_mcu_addr}, {18'd0, start_addr});
                    check({tag, "_size"}, {30'd0, out_mcu_size}, 32'd2);
                    if (nreads < 2) rd[nreads] = out_mcu_addr;
                    nreads++;
                    read_start = 1'b1;
                end
            end
            if (out_done) seen_done = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_nreads"}, nreads, exp_reads);
        check({tag, "_rd0"}, {18'd0, rd[0]}, {18'd0, exp_a0});
        if (exp_reads > 1) check({tag, "_rd1"}, {18'd0, rd[1]}, {18'd0, exp_a1});
        check({tag, "_paddr"}, {18'd0, out_paddr}, {18'd0, exp_paddr});
        check({tag, "_fault"}, {31'd0, out_fault}, {31'd0, exp_fault});
        check({tag, "_done_ren"}, {31'd0, out_mcu_ren}, 32'd0);
        check({tag, "_done_addr"}, {18'd0, out_mcu_addr}, 32'd0);
        @(posedge in_clk);
        #2;
        @(negedge in_clk);
        check({tag, "_done_pulse"}, {31'd0, out_done}, 32'd0);
        check({tag, "_idle_after"}, {31'd0, out_busy}, 32'd0);
        check({tag, "_paddr_held"}, {18'd0, out_paddr}, {18'd0, exp_paddr});
    endtask

    task automatic set_default_mem();
        mem_a0 = 14'h000C;
        mem_d0 = 32'h0000_0401;
        mem_a1 = 14'h0408;
        mem_d1 = 32'h0000_1201;
    endtask

    initial begin
        logic [9:0] busy_v;
        logic [9:0] done_v;
        int         pulses;
        bit         found;

        set_default_mem();
        #1;
        check("rst_busy", {31'd0, out_busy}, 32'd0);
        check("rst_done", {31'd0, out_done}, 32'd0);
        check("rst_fault", {31'd0, out_fault}, 32'd0);
        check("rst_paddr", {18'd0, out_paddr}, 32'd0);
        check("rst_ren", {31'd0, out_mcu_ren}, 32'd0);
        check("rst_addr", {18'd0, out_mcu_addr}, 32'd0);
        check("rst_size", {30'd0, out_mcu_size}, 32'd0);
        #22;
        in_rst_n = 1'b1;

        // Zero-wait walk: L1 at 0x000C, L2 at 0x0408, paddr 0x1215.
        mcu_wait = 0;
        do_walk("zw", 14'h0655, 14'h0000, 2, 14'h000C, 14'h0408, 3, 14'h1215, 1'b0);

        // Four wait cycles per level.
        mcu_wait = 4;
        do_walk("w4", 14'h0655, 14'h0000, 2, 14'h000C, 14'h0408, 11, 14'h1215, 1'b0);

        // L1 descriptor with type bits 00.
        mcu_wait = 0;
        mem_d0 = 32'h0000_0400;
`ifdef TABLE_WALK_FAULT_CHECK_EN
        do_walk("l1z", 14'h0655, 14'h0000, 1, 14'h000C, 14'h0408, 2, 14'h0000, 1'b1);
`else
        do_walk("l1z", 14'h0655, 14'h0000, 2, 14'h000C, 14'h0408, 3, 14'h1215, 1'b0);
`endif

        // All-ones indices with high TTB, and an all-zero L2 descriptor.
        mem_a0 = 14'h3FFC;
        mem_d0 = 32'h0000_2041;
        mem_a1 = 14'h207C;
        mem_d1 = 32'h0000_0000;
        mcu_wait = 1;
`ifdef TABLE_WALK_FAULT_CHECK_EN
        do_walk("hi", 14'h3FFF, 14'h3F80, 2, 14'h3FFC, 14'h207C, 5, 14'h0000, 1'b1);
`else
        do_walk("hi", 14'h3FFF, 14'h3F80, 2, 14'h3FFC, 14'h207C, 5, 14'h001F, 1'b0);
`endif

        // Reset pulse while waiting on the L2 read.
        set_default_mem();
        mcu_wait = 4;
        @(posedge in_clk);
        #2;
        in_req = 1'b1;
        in_mva = 14'h0655;
        in_ttb = 14'h0000;
        @(posedge in_clk);
        #2;
        in_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge in_clk);
            if (out_mcu_ren && out_mcu_addr == 14'h0408) found = 1'b1;
        end
        check("rst_mid_reached_l2", {31'd0, found}, 32'd1);
        #1;
        in_rst_n = 1'b0;
        #1;
        check("rst_mid_ren", {31'd0, out_mcu_ren}, 32'd0);
        check("rst_mid_busy", {31'd0, out_busy}, 32'd0);
        check("rst_mid_done", {31'd0, out_done}, 32'd0);
        check("rst_mid_addr", {18'd0, out_mcu_addr}, 32'd0);
        check("rst_mid_paddr", {18'd0, out_paddr}, 32'd0);
        @(posedge in_clk);
        #3;
        in_rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge in_clk);
            if (out_done || out_busy) pulses++;
        end
        check("rst_mid_quiet", pulses, 0);
        do_walk("post_rst", 14'h0655, 14'h0000, 2, 14'h000C, 14'h0408, 11, 14'h1215, 1'b0);

        // in_req held high: IDLE lasts exactly one cycle between walks.
        mcu_wait = 0;
        @(posedge in_clk);
        #2;
        in_req = 1'b1;
        in_mva = 14'h0655;
        in_ttb = 14'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            busy_v[i] = out_busy;
            done_v[i] = out_done;
            @(posedge in_clk);
            #2;
        end
        in_req = 1'b0;
        check("b2b_busy", {22'd0, busy_v}, {22'd0, 10'b1011101110});
        check("b2b_done", {22'd0, done_v}, {22'd0, 10'b0010001000});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge in_clk);
            if (!out_busy) found = 1'b1;
        end
        check("b2b_drain", {31'd0, found}, 32'd1);
        check("b2b_paddr", {18'd0, out_paddr}, 32'h1215);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
